// File: rtl/merc16_ctrl_pkg.sv
// rtl/merc16_ctrl_pkg.sv - shared constants and types for the MERC-16 main controller
//
// Purpose: state codes, opcode map and class masks, ALU operation codes and
//          datapath mux-select encodings used by merc16_control_unit and
//          merc16_opcode_class.
// Ports:   none (package).
package merc16_ctrl_pkg;

  // Controller states
  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_ALU_WB   = 4'd4;
  localparam state_t S_IMM_WB   = 4'd5;
  localparam state_t S_MEM_ADDR = 4'd6;
  localparam state_t S_MEM_RD   = 4'd7;
  localparam state_t S_MEM_WB   = 4'd8;
  localparam state_t S_MEM_WR   = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_JUMP     = 4'd11;
  localparam state_t S_JAL      = 4'd12;
  localparam state_t S_JR       = 4'd13;
  localparam state_t S_HALT     = 4'd14;

  // Opcode map (IR[15:11])
  localparam logic [4:0] OP_CLASS_MASK = 5'b11000;
  localparam logic [4:0] OP_R_ALU_PAT  = 5'b00000;
  localparam logic [4:0] OP_I_ALU_PAT  = 5'b01000;

  localparam logic [4:0] OP_LUI  = 5'b10000;
  localparam logic [4:0] OP_LLI  = 5'b10001;
  localparam logic [4:0] OP_LW   = 5'b10010;
  localparam logic [4:0] OP_SW   = 5'b10011;
  localparam logic [4:0] OP_BEQ  = 5'b10100;
  localparam logic [4:0] OP_BNE  = 5'b10101;
  localparam logic [4:0] OP_J    = 5'b10110;
  localparam logic [4:0] OP_JAL  = 5'b10111;
  localparam logic [4:0] OP_JR   = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // PC_Source encodings
  localparam logic [1:0] PCS_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCS_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCS_JUMP_IMM   = 2'b10;
  localparam logic [1:0] PCS_REG_A      = 2'b11;

  // RegData encodings
  localparam logic [1:0] RDATA_ALU_OUT = 2'b00;
  localparam logic [1:0] RDATA_MEM     = 2'b01;
  localparam logic [1:0] RDATA_PC      = 2'b10;
  localparam logic [1:0] RDATA_IMM     = 2'b11;

  // RegDest encodings
  localparam logic [1:0] RDEST_RD   = 2'b00;
  localparam logic [1:0] RDEST_RT   = 2'b01;
  localparam logic [1:0] RDEST_LINK = 2'b10;

  // Register-file read-port selects
  localparam logic [1:0] RSRD_RS = 2'b00;
  localparam logic [1:0] RSRD_RD = 2'b01;
  localparam logic [1:0] RSRT_RT = 2'b00;
  localparam logic [1:0] RSRT_RD = 2'b01;

  // ALU operand selects
  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_A   = 1'b1;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_SE  = 2'b10;
  localparam logic [1:0] SRCB_ZE  = 2'b11;

  // One-hot instruction class produced by merc16_opcode_class
  typedef struct packed {
    logic r_alu;
    logic i_alu;
    logic imm;
    logic mem;
    logic branch;
    logic jump;
    logic jal;
    logic jr;
    logic halt;
  } op_class_t;

  function automatic logic in_class(input logic [4:0] op, input logic [4:0] pat);
    return (op & OP_CLASS_MASK) == pat;
  endfunction

endpackage

// File: rtl/merc16_opcode_class.sv
// rtl/merc16_opcode_class.sv - opcode to one-hot instruction class decoder
//
// Purpose: purely combinational classification of the 5-bit opcode into the
//          instruction classes the controller branches on in DECODE.
// Ports:   opcode   in  5  IR[15:11]
//          op_class out    one-hot class (all zero for an undefined opcode)
//          illegal  out 1  opcode matches no defined instruction
module merc16_opcode_class
  import merc16_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class        = '0;
    op_class.r_alu  = in_class(opcode, OP_R_ALU_PAT);
    op_class.i_alu  = in_class(opcode, OP_I_ALU_PAT);
    op_class.imm    = (opcode == OP_LUI) || (opcode == OP_LLI);
    op_class.mem    = (opcode == OP_LW)  || (opcode == OP_SW);
    op_class.branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    op_class.jump   = (opcode == OP_J);
    op_class.jal    = (opcode == OP_JAL);
    op_class.jr     = (opcode == OP_JR);
    op_class.halt   = (opcode == OP_HALT);
  end

  assign illegal = ~|op_class;

endmodule

// File: rtl/merc16_control_unit.sv
// rtl/merc16_control_unit.sv - multicycle main controller for the MERC-16 core
//
// Purpose: sequences fetch/decode/execute/memory/writeback and drives every
//          datapath strobe and mux select. Moore outputs decoded from the
//          registered state (plus Opcode/Zero where the instruction needs it).
// Build option: define MEM_WAIT_EN to stretch FETCH, MEM_RD and MEM_WR to
//          WAIT_STATES+1 cycles each; side-effect strobes fire on the last one.
// Ports:   Clock, Reset (async active-low), Opcode[4:0], Zero in;
//          PC_Source, RegData, RegDest, RsRd, RsRt, ALUSrcA, ALUSrcB, ALUOp,
//          PC_Write, InstData, MemoryWrite, IR_Write, WriteReg, UpperLower,
//          HoldOldPCValue, OldNew, Halted, Illegal out.
module merc16_control_unit
  import merc16_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] Opcode,
  input  logic       Zero,
  output logic [1:0] PC_Source,
  output logic [1:0] RegData,
  output logic [1:0] RegDest,
  output logic [1:0] RsRd,
  output logic [1:0] RsRt,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic       PC_Write,
  output logic       InstData,
  output logic       MemoryWrite,
  output logic       IR_Write,
  output logic       WriteReg,
  output logic       UpperLower,
  output logic       HoldOldPCValue,
  output logic       OldNew,
  output logic       Halted,
  output logic       Illegal
);

  state_t    state;
  state_t    next_state;
  op_class_t op_class;
  logic      op_illegal;
  logic      last_cycle;

  merc16_opcode_class u_opcode_class (
    .opcode   (Opcode),
    .op_class (op_class),
    .illegal  (op_illegal)
  );

`ifdef MEM_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  logic [CNT_W-1:0] wait_cnt;
  logic             held_state;

  assign held_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign last_cycle = !held_state || (wait_cnt == '0);

  // Outside the held states the counter sits preloaded, so every entry into
  // a held state starts a fresh count without an explicit load event.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= CNT_LOAD;
    end else if (!last_cycle) begin
      wait_cnt <= wait_cnt - 1'b1;
    end else begin
      wait_cnt <= CNT_LOAD;
    end
  end
`else
  logic unused_wait_states;

  assign unused_wait_states = (WAIT_STATES != 0);
  assign last_cycle         = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (last_cycle) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (op_class.r_alu)       next_state = S_EXEC_R;
        else if (op_class.i_alu)  next_state = S_EXEC_I;
        else if (op_class.imm)    next_state = S_IMM_WB;
        else if (op_class.mem)    next_state = S_MEM_ADDR;
        else if (op_class.branch) next_state = S_BRANCH;
        else if (op_class.jump)   next_state = S_JUMP;
        else if (op_class.jal)    next_state = S_JAL;
        else if (op_class.jr)     next_state = S_JR;
        else if (op_class.halt)   next_state = S_HALT;
        else                      next_state = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
      // LW and SW differ only in Opcode[0]
      S_MEM_ADDR: next_state = Opcode[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (last_cycle) next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (last_cycle) next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    PC_Source      = PCS_ALU_RESULT;
    RegData        = RDATA_ALU_OUT;
    RegDest        = RDEST_RD;
    RsRd           = RSRD_RS;
    RsRt           = RSRT_RT;
    ALUSrcA        = SRCA_PC;
    ALUSrcB        = SRCB_B;
    ALUOp          = ALU_ADD;
    PC_Write       = 1'b0;
    InstData       = 1'b0;
    MemoryWrite    = 1'b0;
    IR_Write       = 1'b0;
    WriteReg       = 1'b0;
    UpperLower     = 1'b0;
    HoldOldPCValue = 1'b0;
    OldNew         = 1'b0;
    Halted         = 1'b0;
    Illegal        = 1'b0;

    case (state)
      S_FETCH: begin
        IR_Write       = 1'b1;
        HoldOldPCValue = 1'b1;
        ALUSrcB        = SRCB_ONE;
        PC_Write       = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH can select ALU_Out.
        ALUSrcB = SRCB_SE;
        Illegal = op_illegal;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_A;
        ALUOp   = {1'b0, Opcode[2:0]};
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = Opcode[2] ? SRCB_ZE : SRCB_SE;
        ALUOp   = {1'b1, Opcode[2:0]};
      end
      S_ALU_WB: begin
        WriteReg = 1'b1;
        RegDest  = Opcode[3] ? RDEST_RT : RDEST_RD;
      end
      S_IMM_WB: begin
        WriteReg   = 1'b1;
        RegData    = RDATA_IMM;
        RegDest    = RDEST_RT;
        UpperLower = ~Opcode[0];
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_SE;
      end
      S_MEM_RD: begin
        InstData = 1'b1;
      end
      S_MEM_WB: begin
        WriteReg = 1'b1;
        RegData  = RDATA_MEM;
        RegDest  = RDEST_RT;
      end
      S_MEM_WR: begin
        InstData    = 1'b1;
        MemoryWrite = 1'b1;
        RsRt        = RSRT_RD;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_A;
        ALUOp     = ALU_SUB;
        PC_Source = PCS_ALU_OUT;
        // BEQ takes on equal, BNE (Opcode[0]=1) on not-equal
        PC_Write  = Opcode[0] ? ~Zero : Zero;
      end
      S_JUMP: begin
        PC_Source = PCS_JUMP_IMM;
        PC_Write  = 1'b1;
      end
      S_JAL: begin
        PC_Source = PCS_JUMP_IMM;
        PC_Write  = 1'b1;
        WriteReg  = 1'b1;
        RegData   = RDATA_PC;
        RegDest   = RDEST_LINK;
      end
      S_JR: begin
        PC_Source = PCS_REG_A;
        PC_Write  = 1'b1;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
      end
    endcase

    if (!last_cycle) begin
      PC_Write    = 1'b0;
      IR_Write    = 1'b0;
      MemoryWrite = 1'b0;
      WriteReg    = 1'b0;
    end

    // Reset gates the decode so nothing writes while Reset is held low,
    // even though the state register already reads FETCH.
    if (!Reset) begin
      PC_Source      = 2'b00;
      RegData        = 2'b00;
      RegDest        = 2'b00;
      RsRd           = 2'b00;
      RsRt           = 2'b00;
      ALUSrcA        = 1'b0;
      ALUSrcB        = 2'b00;
      ALUOp          = 4'b0000;
      PC_Write       = 1'b0;
      InstData       = 1'b0;
      MemoryWrite    = 1'b0;
      IR_Write       = 1'b0;
      WriteReg       = 1'b0;
      UpperLower     = 1'b0;
      HoldOldPCValue = 1'b0;
      OldNew         = 1'b0;
      Halted         = 1'b0;
      Illegal        = 1'b0;
    end
  end

endmodule

// File: tb/tb_merc16_control_unit.sv
// tb/tb_merc16_control_unit.sv - directed self-checking bench for merc16_control_unit
module tb_merc16_control_unit;

  logic       Clock;
  logic       Reset;
  logic [4:0] Opcode;
  logic       Zero;
  logic [1:0] PC_Source, RegData, RegDest, RsRd, RsRt, ALUSrcB;
  logic       ALUSrcA;
  logic [3:0] ALUOp;
  logic       PC_Write, InstData, MemoryWrite, IR_Write, WriteReg;
  logic       UpperLower, HoldOldPCValue, OldNew, Halted, Illegal;

  int tests_run;
  int tests_failed;

  merc16_control_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Opcode         (Opcode),
    .Zero           (Zero),
    .PC_Source      (PC_Source),
    .RegData        (RegData),
    .RegDest        (RegDest),
    .RsRd           (RsRd),
    .RsRt           (RsRt),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .ALUOp          (ALUOp),
    .PC_Write       (PC_Write),
    .InstData       (InstData),
    .MemoryWrite    (MemoryWrite),
    .IR_Write       (IR_Write),
    .WriteReg       (WriteReg),
    .UpperLower     (UpperLower),
    .HoldOldPCValue (HoldOldPCValue),
    .OldNew         (OldNew),
    .Halted         (Halted),
    .Illegal        (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observed control word; strobe field order is
  // {PC_Write, InstData, MemoryWrite, IR_Write, WriteReg, UpperLower,
  //  HoldOldPCValue, OldNew, Halted, Illegal}
  logic [26:0] obs;
  assign obs = {PC_Source, RegData, RegDest, RsRd, RsRt, ALUSrcA, ALUSrcB, ALUOp,
                PC_Write, InstData, MemoryWrite, IR_Write, WriteReg, UpperLower,
                HoldOldPCValue, OldNew, Halted, Illegal};

  function automatic logic [26:0] cw(input logic [1:0] pcs, input logic [1:0] rdat,
                                     input logic [1:0] rdst, input logic [1:0] rsrd,
                                     input logic [1:0] rsrt, input logic srca,
                                     input logic [1:0] srcb, input logic [3:0] op,
                                     input logic [9:0] stb);
    return {pcs, rdat, rdst, rsrd, rsrt, srca, srcb, op, stb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare the current cycle, then move to the middle of the next one.
  task automatic step(input string tag, input logic [26:0] exp);
    check(tag, {5'b0, obs}, {5'b0, exp});
    @(negedge Clock);
    #1;
  endtask

  task automatic begin_instr(input logic [4:0] op, input logic z);
    Opcode = op;
    Zero   = z;
  endtask

  logic [26:0] w_f, w_d, w_halt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset  = 1'b0;
    Opcode = 5'b00000;
    Zero   = 1'b0;

    w_f    = cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 4'h0, 10'b1001001000);
    w_d    = cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 4'h0, 10'b0000000000);
    w_halt = cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000000010);

    // Reset state, before and after a clock edge under reset
    #3;
    check("reset_word", {5'b0, obs}, 32'h0);
    @(posedge Clock);
    #2;
    check("reset_word_after_edge", {5'b0, obs}, 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;

    // ADD: 4 cycles
    begin_instr(5'b00000, 1'b0);
    step("add.fetch", w_f);
    step("add.decode", w_d);
    step("add.exec", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0000, 10'b0));
    step("add.wb", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // R-ALU with a nonzero function
    begin_instr(5'b00011, 1'b0);
    step("r3.fetch", w_f);
    step("r3.decode", w_d);
    step("r3.exec", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0011, 10'b0));
    step("r3.wb", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // I-ALU logical (Opcode[2]=1 selects ZE)
    begin_instr(5'b01101, 1'b0);
    step("ilog.fetch", w_f);
    step("ilog.decode", w_d);
    step("ilog.exec", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 4'b1101, 10'b0));
    step("ilog.wb", cw(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // I-ALU arithmetic (SE)
    begin_instr(5'b01010, 1'b0);
    step("iari.fetch", w_f);
    step("iari.decode", w_d);
    step("iari.exec", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 4'b1010, 10'b0));
    step("iari.wb", cw(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // LW: 5 cycles
    begin_instr(5'b10010, 1'b0);
    step("lw.fetch", w_f);
    step("lw.decode", w_d);
    step("lw.addr", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 4'h0, 10'b0));
    step("lw.rd", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0100000000));
    step("lw.wb", cw(2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // SW: 4 cycles
    begin_instr(5'b10011, 1'b0);
    step("sw.fetch", w_f);
    step("sw.decode", w_d);
    step("sw.addr", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 4'h0, 10'b0));
    step("sw.wr", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 4'h0, 10'b0110000000));

    // BEQ / BNE with both Zero values
    begin_instr(5'b10100, 1'b1);
    step("beq_z1.fetch", w_f);
    step("beq_z1.decode", w_d);
    step("beq_z1.branch", cw(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0001, 10'b1000000000));
    begin_instr(5'b10100, 1'b0);
    step("beq_z0.fetch", w_f);
    step("beq_z0.decode", w_d);
    step("beq_z0.branch", cw(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0001, 10'b0));
    begin_instr(5'b10101, 1'b1);
    step("bne_z1.fetch", w_f);
    step("bne_z1.decode", w_d);
    step("bne_z1.branch", cw(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0001, 10'b0));
    begin_instr(5'b10101, 1'b0);
    step("bne_z0.fetch", w_f);
    step("bne_z0.decode", w_d);
    step("bne_z0.branch", cw(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0001, 10'b1000000000));

    // J, JAL, JR
    begin_instr(5'b10110, 1'b0);
    step("j.fetch", w_f);
    step("j.decode", w_d);
    step("j.jump", cw(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b1000000000));
    begin_instr(5'b10111, 1'b0);
    step("jal.fetch", w_f);
    step("jal.decode", w_d);
    step("jal.link", cw(2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b1000100000));
    begin_instr(5'b11000, 1'b0);
    step("jr.fetch", w_f);
    step("jr.decode", w_d);
    step("jr.jump", cw(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b1000000000));

    // LUI / LLI
    begin_instr(5'b10000, 1'b0);
    step("lui.fetch", w_f);
    step("lui.decode", w_d);
    step("lui.wb", cw(2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000110000));
    begin_instr(5'b10001, 1'b0);
    step("lli.fetch", w_f);
    step("lli.decode", w_d);
    step("lli.wb", cw(2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 4'h0, 10'b0000100000));

    // Illegal opcodes: one-cycle pulse in DECODE, then straight back to FETCH
    begin_instr(5'b11010, 1'b0);
    step("ill1.fetch", w_f);
    step("ill1.decode", w_d | 27'd1);
    begin_instr(5'b11110, 1'b0);
    step("ill2.fetch", w_f);
    step("ill2.decode", w_d | 27'd1);

    // Reset asserted mid MEM_WR
    begin_instr(5'b10011, 1'b0);
    step("swr.fetch", w_f);
    step("swr.decode", w_d);
    step("swr.addr", cw(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 4'h0, 10'b0));
    check("swr.wr_before_reset", {31'b0, MemoryWrite}, 32'd1);
    Reset = 1'b0;
    #1;
    check("swr.memwrite_drop", {31'b0, MemoryWrite}, 32'd0);
    check("swr.reset_word", {5'b0, obs}, 32'h0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;

    // HALT: sticky until reset
    begin_instr(5'b11111, 1'b0);
    step("halt.fetch", w_f);
    step("halt.decode", w_d);
    step("halt.c3", w_halt);
    step("halt.c4", w_halt);
    step("halt.c5", w_halt);
    begin_instr(5'b00000, 1'b0);
    step("halt.c6_newop", w_halt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
